cp0_excp_seq: RTL



---
 rtl/cp0_excp_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cp0_excp_seq.sv
// CP0 exception/interrupt/ERET sequencer: owns the CP0 write port, sequences EPC/Status
// updates, flushes and redirects the pipeline. Interrupts built only with CP0_SEQ_INT_EN.
module cp0_excp_seq #(
  parameter logic [31:0] EXC_VECTOR      = 32'h0000_0020,
  parameter logic [4:0]  CP0_STATUS_ADDR = 5'd12,
  parameter logic [4:0]  CP0_CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  CP0_EPC_ADDR    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_data_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delay_i,
  input  logic        excp_valid_i,
  input  logic [4:0]  excp_code_i,
  input  logic        eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o,
  output logic [4:0]  exc_code_o,
  output logic        bd_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, WR_EPC, WR_STATUS, ERET_ST, REDIRECT} state_t;

  state_t      state, state_nx;
  logic [31:0] epc_val, target;
  logic        buf_vld;
  logic [4:0]  buf_addr;
  logic [31:0] buf_data;
  logic        int_pend, idle, replay, take_exc, take_eret;

`ifdef CP0_SEQ_INT_EN
  assign int_pend = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]);
`else
  assign int_pend = 1'b0;
  logic unused_cause;
  assign unused_cause = ^cause_i;
`endif

  // Cause is captured elsewhere from exc_code_o/bd_o; its index is not needed here.
  logic unused_cause_addr;
  assign unused_cause_addr = ^CP0_CAUSE_ADDR;

  assign idle      = (state == IDLE);
  assign replay    = idle & buf_vld;
  assign take_exc  = idle & ~buf_vld & mem_valid_i & (int_pend | excp_valid_i);
  assign take_eret = idle & ~buf_vld & mem_valid_i & ~int_pend & ~excp_valid_i & eret_i;

  assign busy_o  = ~idle;
  assign stall_o = busy_o | take_exc | take_eret | replay;

  always_comb begin
    state_nx    = state;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = '0;
    cp0_data_o  = '0;
    flush_o     = 1'b0;
    new_pc_o    = '0;
    case (state)
      IDLE: begin
        if (replay) begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = buf_addr;
          cp0_data_o  = buf_data;
        end else if (wb_we_i) begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = wb_waddr_i;
          cp0_data_o  = wb_data_i;
        end
        if (take_exc)       state_nx = WR_EPC;
        else if (take_eret) state_nx = ERET_ST;
      end
      WR_EPC: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = CP0_EPC_ADDR;
        cp0_data_o  = epc_val;
        state_nx    = WR_STATUS;
      end
      WR_STATUS: begin
        // status_i here already reflects any MTC0 passed through in the accept cycle
        cp0_we_o    = 1'b1;
        cp0_waddr_o = CP0_STATUS_ADDR;
        cp0_data_o  = status_i | 32'h2;
        state_nx    = REDIRECT;
      end
      ERET_ST: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = CP0_STATUS_ADDR;
        cp0_data_o  = status_i & ~32'h2;
        state_nx    = REDIRECT;
      end
      REDIRECT: begin
        flush_o  = 1'b1;
        new_pc_o = target;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      epc_val    <= '0;
      target     <= '0;
      exc_code_o <= '0;
      bd_o       <= 1'b0;
      buf_vld    <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
    end else begin
      state <= state_nx;
      if (take_exc) begin
        epc_val    <= mem_in_delay_i ? mem_pc_i - 32'd4 : mem_pc_i;
        bd_o       <= mem_in_delay_i;
        exc_code_o <= int_pend ? 5'd0 : excp_code_i;
      end
      if (take_eret)              target <= epc_i;
      else if (state == WR_STATUS) target <= EXC_VECTOR;
      // Port not free: park the WB write; a newer one simply overwrites the entry.
      if (wb_we_i && (!idle || buf_vld)) begin
        buf_vld  <= 1'b1;
        buf_addr <= wb_waddr_i;
        buf_data <= wb_data_i;
      end else if (replay) begin
        buf_vld <= 1'b0;
      end
    end
  end

endmodule
